// File: rtl/ad_con_pkg.sv
// Shared types and default parameters for the ad_con serial DAC ramp driver.
package ad_con_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_SCK_HALF = 4;
    localparam int DEF_GAP      = 8;
    localparam int DEF_STEP     = 1;

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ad_con_sck_gen.sv
// SCK_HALF divider: one-cycle rise/fall strobes, low phase first, held in reset while disabled.
module ad_con_sck_gen
    import ad_con_pkg::*;
#(
    parameter int SCK_HALF = DEF_SCK_HALF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_rise,
    output logic o_fall
);

    localparam int                DIV_W    = cnt_width(SCK_HALF);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCK_HALF - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_phase;
    logic             w_tick;

    assign w_tick = i_en && (r_div == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_div   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_div   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_div   <= r_div + DIV_W'(1);
        end
    end

    // r_phase==0 means SCK is currently low, so the next tick is a rise.
    assign o_rise = w_tick & ~r_phase;
    assign o_fall = w_tick &  r_phase;

endmodule

// File: rtl/ad_con.sv
// Free-running 3-wire DAC driver: streams a sawtooth ramp, one DATA_W-bit word per CSLD frame.
module ad_con
    import ad_con_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SCK_HALF = DEF_SCK_HALF,
    parameter int GAP      = DEF_GAP,
    parameter int STEP     = DEF_STEP
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic       SCK,
    output logic       Dout,
    output logic       CSLD,
    output logic [1:0] o_dbg_state
);

    localparam int               CNT_W     = cnt_width((GAP > SCK_HALF) ? GAP : SCK_HALF);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SCK_HALF - 1);
    localparam int               BIT_W     = cnt_width(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] STEP_V   = DATA_W'(STEP);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_code;
    logic              r_sck;
    logic              r_csld;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [DATA_W-1:0] w_code_nxt;
    logic              w_sck_nxt;
    logic              w_csld_nxt;
    logic              w_rise;
    logic              w_fall;
    logic              w_sck_en;

    assign w_sck_en = (r_state == SHIFT);

    ad_con_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_en    (w_sck_en),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_code  <= '0;
            r_sck   <= 1'b0;
            r_csld  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_code  <= w_code_nxt;
            r_sck   <= w_sck_nxt;
            r_csld  <= w_csld_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_code_nxt  = r_code;
        w_sck_nxt   = r_sck;
        w_csld_nxt  = r_csld;

        case (r_state)
            IDLE: begin
                w_sck_nxt  = 1'b0;
                w_csld_nxt = 1'b1;
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_shift_nxt = r_code;
                    w_csld_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end

            SHIFT: begin
                w_csld_nxt = 1'b0;
                if (w_rise) begin
                    w_sck_nxt = 1'b1;
                end else if (w_fall) begin
                    w_sck_nxt = 1'b0;
                    // The final fall leaves the LSB on Dout for HOLD and the gap.
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end

            HOLD: begin
                w_sck_nxt = 1'b0;
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_csld_nxt  = 1'b1;
                    w_code_nxt  = r_code + STEP_V;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_sck_nxt   = 1'b0;
                w_csld_nxt  = 1'b1;
            end
        endcase
    end

    assign SCK         = r_sck;
    assign Dout        = r_shift[DATA_W-1];
    assign CSLD        = r_csld;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ad_con.sv
// Bench for ad_con: three parameterisations monitored against a frame-level timing/ramp model.
module tb_ad_con;

    localparam int N_DUT   = 3;
    localparam int W       = 16;
    localparam int MAX_LOG = 8;
    localparam int H_OF [N_DUT] = '{4, 4, 1};
    localparam int G_OF [N_DUT] = '{8, 8, 1};
    localparam int S_OF [N_DUT] = '{1, 32'h4000, 1};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N_DUT-1:0] rst_n;
    logic sck0, sck1, sck2, dout0, dout1, dout2, csld0, csld1, csld2;
    logic [1:0] dbg0, dbg1, dbg2;
    logic [N_DUT-1:0] sck_v, dout_v, csld_v;
    assign sck_v  = {sck2, sck1, sck0};
    assign dout_v = {dout2, dout1, dout0};
    assign csld_v = {csld2, csld1, csld0};

    ad_con u_dut0 (.CLK(clk), .RST_N(rst_n[0]), .SCK(sck0), .Dout(dout0), .CSLD(csld0), .o_dbg_state(dbg0));
    ad_con #(.STEP(32'h4000)) u_dut1 (.CLK(clk), .RST_N(rst_n[1]), .SCK(sck1), .Dout(dout1), .CSLD(csld1), .o_dbg_state(dbg1));
    ad_con #(.SCK_HALF(1), .GAP(1)) u_dut2 (.CLK(clk), .RST_N(rst_n[2]), .SCK(sck2), .Dout(dout2), .CSLD(csld2), .o_dbg_state(dbg2));

    // ---------------- scoreboard counters ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min_v);
        n_chk++;
        if (act < min_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, required >= %0d", name, act, min_v);
        end
    endtask

    // ---------------- frame monitor / reference model ----------------
    int t_rel [N_DUT], t_fall [N_DUT], t_srise [N_DUT], t_sfall [N_DUT], t_dchg [N_DUT];
    int rise_cnt [N_DUT], frames_done [N_DUT], fall_cnt [N_DUT];
    bit in_frame [N_DUT], have_fall [N_DUT], viol [N_DUT];
    logic prev_sck [N_DUT], prev_csld [N_DUT], prev_dout [N_DUT];
    logic [W-1:0] shreg [N_DUT];
    logic [W-1:0] last_code [N_DUT];
    int log_code [N_DUT][MAX_LOG], log_low [N_DUT][MAX_LOG], log_per [N_DUT][MAX_LOG];
    int log_gap0 [N_DUT], log_sck_per [N_DUT];

    always @(negedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            if (!rst_n[i]) begin
                t_rel[i] = cyc; t_dchg[i] = cyc;
                in_frame[i] = 0; have_fall[i] = 0; viol[i] = 0;
                rise_cnt[i] = 0; frames_done[i] = 0; fall_cnt[i] = 0;
                prev_sck[i] = sck_v[i]; prev_csld[i] = csld_v[i]; prev_dout[i] = dout_v[i];
            end else begin
                int h;
                logic [W-1:0] exp_code;
                h = H_OF[i];
                if (dout_v[i] !== prev_dout[i]) t_dchg[i] = cyc;
                if (csld_v[i] && (sck_v[i] || (sck_v[i] !== prev_sck[i]))) viol[i] = 1;

                if (prev_csld[i] && !csld_v[i]) begin
                    check($sformatf("sck_while_csld_high_%0d", i), 32'(viol[i]), 0);
                    viol[i] = 0;
                    check($sformatf("gap_%0d", i), cyc - t_rel[i], G_OF[i]);
                    if (!have_fall[i]) log_gap0[i] = cyc - t_rel[i];
                    if (have_fall[i]) begin
                        check($sformatf("period_%0d", i), cyc - t_fall[i], h * (2 * W + 1) + G_OF[i]);
                        if (fall_cnt[i] < MAX_LOG) log_per[i][fall_cnt[i]] = cyc - t_fall[i];
                    end
                    t_fall[i] = cyc; have_fall[i] = 1; in_frame[i] = 1;
                    rise_cnt[i] = 0; shreg[i] = '0;
                    fall_cnt[i]++;
                end

                if (in_frame[i] && !prev_sck[i] && sck_v[i]) begin
                    check($sformatf("sck_rise_time_%0d_bit%0d", i, rise_cnt[i]), cyc - t_fall[i], (2 * rise_cnt[i] + 1) * h);
                    check_ge($sformatf("dout_setup_%0d_bit%0d", i, rise_cnt[i]), cyc - t_dchg[i], h);
                    if (rise_cnt[i] == 1 && fall_cnt[i] == 1) log_sck_per[i] = cyc - t_srise[i];
                    shreg[i] = {shreg[i][W-2:0], dout_v[i]};
                    rise_cnt[i]++;
                    t_srise[i] = cyc;
                end

                if (in_frame[i] && prev_sck[i] && !sck_v[i]) begin
                    check($sformatf("sck_high_%0d", i), cyc - t_srise[i], h);
                    check($sformatf("dout_hold_%0d", i), 32'((t_dchg[i] <= t_srise[i]) || (t_dchg[i] == cyc)), 1);
                    t_sfall[i] = cyc;
                end

                if (in_frame[i] && !prev_csld[i] && csld_v[i]) begin
                    exp_code = W'(frames_done[i] * S_OF[i]);
                    check($sformatf("rises_per_frame_%0d", i), rise_cnt[i], W);
                    check($sformatf("csld_low_%0d", i), cyc - t_fall[i], h * (2 * W + 1));
                    check($sformatf("csld_tail_%0d", i), cyc - t_sfall[i], h);
                    check($sformatf("code_%0d_f%0d", i, frames_done[i]), 32'(shreg[i]), 32'(exp_code));
                    if (frames_done[i] < MAX_LOG) begin
                        log_code[i][frames_done[i]] = int'(shreg[i]);
                        log_low[i][frames_done[i]]  = cyc - t_fall[i];
                    end
                    last_code[i] = shreg[i];
                    frames_done[i]++;
                    in_frame[i] = 0;
                    t_rel[i] = cyc;
                end

                prev_sck[i] = sck_v[i]; prev_csld[i] = csld_v[i]; prev_dout[i] = dout_v[i];
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        int           inst;
        int           frame;
        logic [W-1:0] code;
        int           low;
        int           per;
    } vec_t;

    vec_t vecs [11];

    task automatic reset_pulse_check(input int idx, input string tag);
        rst_n[idx] = 1'b0;
        #1;
        check($sformatf("%s_sck_%0d", tag, idx),  32'(sck_v[idx]),  0);
        check($sformatf("%s_csld_%0d", tag, idx), 32'(csld_v[idx]), 1);
        check($sformatf("%s_dout_%0d", tag, idx), 32'(dout_v[idx]), 0);
    endtask

    task automatic wait_frames(input int idx, input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (frames_done[idx] < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check($sformatf("%s_frames_reached_%0d", tag, idx), 32'(frames_done[idx] >= n), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int idx;
        vecs[0]  = '{0, 0, 16'h0000, 132, 0};
        vecs[1]  = '{0, 1, 16'h0001, 132, 140};
        vecs[2]  = '{0, 2, 16'h0002, 132, 140};
        vecs[3]  = '{1, 0, 16'h0000, 132, 0};
        vecs[4]  = '{1, 1, 16'h4000, 132, 140};
        vecs[5]  = '{1, 2, 16'h8000, 132, 140};
        vecs[6]  = '{1, 3, 16'hC000, 132, 140};
        vecs[7]  = '{1, 4, 16'h0000, 132, 140};
        vecs[8]  = '{2, 0, 16'h0000, 33, 0};
        vecs[9]  = '{2, 1, 16'h0001, 33, 34};
        vecs[10] = '{2, 2, 16'h0002, 33, 34};
        for (int i = 0; i < N_DUT; i++) begin
            log_gap0[i] = -1;
            log_sck_per[i] = -1;
            for (int f = 0; f < MAX_LOG; f++) begin
                log_code[i][f] = -1; log_low[i][f] = -1; log_per[i][f] = -1;
            end
        end

        // Reset values while reset is held.
        rst_n = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("reset_sck_%0d", i),  32'(sck_v[i]),  0);
            check($sformatf("reset_dout_%0d", i), 32'(dout_v[i]), 0);
            check($sformatf("reset_csld_%0d", i), 32'(csld_v[i]), 1);
        end
        @(negedge clk);
        #1;
        rst_n = '1;

        // Free run until the wrap instance has produced five frames.
        wait_frames(1, 5, 1000, "run");
        wait_frames(0, 3, 100, "run");

        for (int v = 0; v < 11; v++) begin
            check($sformatf("tbl_code_i%0d_f%0d", vecs[v].inst, vecs[v].frame),
                  32'(log_code[vecs[v].inst][vecs[v].frame]), 32'(vecs[v].code));
            check($sformatf("tbl_low_i%0d_f%0d", vecs[v].inst, vecs[v].frame),
                  32'(log_low[vecs[v].inst][vecs[v].frame]), 32'(vecs[v].low));
            if (vecs[v].frame > 0)
                check($sformatf("tbl_period_i%0d_f%0d", vecs[v].inst, vecs[v].frame),
                      32'(log_per[vecs[v].inst][vecs[v].frame]), 32'(vecs[v].per));
        end
        check("first_gap_0", 32'(log_gap0[0]), 8);
        check("first_gap_2", 32'(log_gap0[2]), 1);
        check("sck_period_0", 32'(log_sck_per[0]), 8);
        check("sck_period_2", 32'(log_sck_per[2]), 2);

        // Mid-frame reset just after the 5th SCK rise.
        found = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (in_frame[0] && rise_cnt[0] == 5) begin
                found = 1;
                break;
            end
        end
        check("wait_5th_rise", 32'(found), 1);
        check("sck_high_before_abort", 32'(sck_v[0]), 1);
        reset_pulse_check(0, "midframe");
        repeat (3) @(negedge clk);
        #1;
        rst_n[0] = 1'b1;
        wait_frames(0, 1, 400, "after_abort");
        check("after_abort_code", 32'(last_code[0]), 0);

        // Randomly timed asynchronous resets on the default and fast instances.
        for (int r = 0; r < 4; r++) begin
            idx = (r % 2 == 0) ? 0 : 2;
            repeat ($urandom_range(10, 300)) @(posedge clk);
            #($urandom_range(1, 3));
            reset_pulse_check(idx, $sformatf("rand%0d", r));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #1;
            rst_n[idx] = 1'b1;
            wait_frames(idx, 2, 400, $sformatf("rand%0d", r));
            check($sformatf("rand%0d_second_code_%0d", r, idx), 32'(last_code[idx]), 32'(W'(S_OF[idx])));
        end

        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
